retire_trace_fifo: RTL and testbench
====================================

// Module: retire_trace_fifo
// PURPOSE
//   Consumes the write-back stage's retirement stream: one record per retired instruction
//   (PC, instruction word, register write). Buffers records in a FIFO and drains them through a
//   valid/ready port to the golden-model checker. Signals end of test once the syscall has drained.
// PARAMETERS
//   DEPTH    16                 FIFO entries; power of two, >= 2
//   ADDR_W   $clog2(DEPTH)      pointer width (derived, do not override)
// PORTS
//   clk          in   1    single clock, rising edge
//   reset        in   1    synchronous, active-low; acts on the clk edge where reset==0
//   retire_valid in   1    WB retired an instruction this cycle
//   retire_pc    in   32   PC of retired instruction
//   retire_instr in   32   instruction word
//   retire_we    in   1    instruction wrote the register file
//   retire_waddr in   5    destination register
//   retire_wdata in   32   value written
//   out_valid    out  1    head record available
//   out_ready    in   1    consumer accepts head this cycle
//   out_pc/out_instr/out_we/out_waddr/out_wdata  out  32/32/1/5/32  head record fields
//   count        out  ADDR_W+1  entries currently held
//   retired_cnt  out  32   records accepted since reset; wraps 0xFFFFFFFF->0
//   overflow     out  1    sticky: a record was dropped because the FIFO was full
//   done         out  1    sticky: syscall record (instr==32'h0000000C) popped
// BEHAVIOUR
//   Reset (reset==0 at edge): rd/wr ptr=0, count=0, out_valid=0, retired_cnt=0, overflow=0,
//     done=0, FSM=RUN. Storage contents are not cleared. Out fields are don't-care while out_valid=0.
//   pop  = out_valid & out_ready.
//   push = retire_valid & (FSM==RUN) & (count<DEPTH | pop).
//   Full with a simultaneous pop: the push is accepted and count stays DEPTH.
//   Full without a pop: the record is dropped, overflow<=1, retired_cnt does not change.
//   Empty with a simultaneous push: no bypass; the record appears at the head the next cycle.
//   Latency: a record pushed at edge N gives out_valid=1 after edge N (first-word fall-through).
//     Head fields are driven from the rd_ptr slot.
//   count += push - pop. Pointers are ADDR_W bits and wrap modulo DEPTH.
//   out_valid = (count!=0) & (FSM!=HALTED).
//   The head is held stable while out_valid & ~out_ready.
//   retired_cnt increments on each accepted push.
//   FSM:
//     RUN     -> HALTING on a push with retire_instr==32'h0000000C. That record is still enqueued.
//     HALTING -> HALTED on a pop whose out_instr==32'h0000000C. That edge sets done<=1.
//     HALTED  -> absorbing until reset. No push, no pop, out_valid=0.
//   In HALTING, retire_valid is ignored: no push, no overflow, no retired_cnt increment.
//     Entries ahead of the syscall keep draining.
//   Reset mid-operation discards all buffered records and returns to RUN in one cycle.
// TESTING
//   T1 Single record: push pc=0x00400000, instr=0x20020005, we=1, waddr=2, wdata=5 into an empty FIFO.
//      Next cycle out_valid=1 with identical fields. Pop with out_ready=1 -> count=0, retired_cnt=1.
//   T2 Fill/overflow, DEPTH=16, out_ready=0: push 17 records -> count=16, overflow=1,
//      retired_cnt=16. Drain all 16 -> PCs in push order, 17th record absent.
//   T3 Full with simultaneous push+pop: record 17 accepted, count stays 16, overflow stays 0,
//      record 17 is the last to drain.
//   T4 Backpressure: toggle out_ready pseudo-randomly while pushing 100 records.
//      All 100 drain in order, head fields stable whenever out_valid & ~out_ready.
//   T5 End of test: push A, B, then instr=0x0000000C, then C. C is ignored.
//      Drain A, B, syscall -> done=1 on the syscall pop edge, then out_valid=0.
//      retired_cnt=3, FSM stays HALTED.
//   T6 Reset mid-operation: 5 records buffered, hold reset=0 for 1 edge.
//      -> count=0, out_valid=0, done=0, overflow=0, retired_cnt=0.
//      The next push appears normally one cycle later.

Source files
------------

// File: rtl/retire_trace_fifo.sv
// Retirement trace buffer: queues write-back records for the golden-model
// checker and raises done once the syscall record has drained.
module retire_trace_fifo #(
  parameter int DEPTH = 16,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              retire_valid,
  input  logic [31:0]       retire_pc,
  input  logic [31:0]       retire_instr,
  input  logic              retire_we,
  input  logic [4:0]        retire_waddr,
  input  logic [31:0]       retire_wdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_pc,
  output logic [31:0]       out_instr,
  output logic              out_we,
  output logic [4:0]        out_waddr,
  output logic [31:0]       out_wdata,
  output logic [ADDR_W:0]   count,
  output logic [31:0]       retired_cnt,
  output logic              overflow,
  output logic              done
);

  localparam logic [31:0] SYSCALL = 32'h0000_000C;
  localparam logic [ADDR_W:0] CNT_FULL = (ADDR_W + 1)'(DEPTH);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
  } rec_t;

  typedef enum logic [1:0] {
    RUN,
    HALTING,
    HALTED
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [31:0]       retired_cnt_q, retired_cnt_d;
  logic              overflow_q, overflow_d;
  logic              done_q, done_d;

  rec_t mem_q [DEPTH];
  rec_t rec_in;
  rec_t head;

  logic full;
  logic accept;
  logic push;
  logic pop;
  logic valid;

  always_comb begin
    rec_in = '{
      pc:    retire_pc,
      instr: retire_instr,
      we:    retire_we,
      waddr: retire_waddr,
      wdata: retire_wdata
    };
    head   = mem_q[rd_ptr_q];
    full   = (count_q == CNT_FULL);
    valid  = (count_q != '0) && (state_q != HALTED);
    pop    = valid && out_ready;
    accept = retire_valid && (state_q == RUN);
    push   = accept && (!full || pop);
  end

  assign out_valid   = valid;
  assign out_pc      = head.pc;
  assign out_instr   = head.instr;
  assign out_we      = head.we;
  assign out_waddr   = head.waddr;
  assign out_wdata   = head.wdata;
  assign count       = count_q;
  assign retired_cnt = retired_cnt_q;
  assign overflow    = overflow_q;
  assign done        = done_q;

  always_comb begin
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    count_d       = count_q;
    retired_cnt_d = retired_cnt_q;
    overflow_d    = overflow_q;
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (push) begin
      wr_ptr_d      = wr_ptr_q + 1'b1;
      retired_cnt_d = retired_cnt_q + 32'd1;
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    // A dropped record only counts as overflow while the FIFO is still taking input.
    if (accept && !push) begin
      overflow_d = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    done_d  = done_q;
    unique case (state_q)
      RUN: begin
        if (push && (retire_instr == SYSCALL)) begin
          state_d = HALTING;
        end
      end
      HALTING: begin
        if (pop && (head.instr == SYSCALL)) begin
          state_d = HALTED;
          done_d  = 1'b1;
        end
      end
      HALTED: begin
        state_d = HALTED;
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= RUN;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      count_q       <= '0;
      retired_cnt_q <= '0;
      overflow_q    <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      count_q       <= count_d;
      retired_cnt_q <= retired_cnt_d;
      overflow_q    <= overflow_d;
      done_q        <= done_d;
    end
  end

  // Storage is deliberately left uncleared by reset.
  always_ff @(posedge clk) begin
    if (reset && push) begin
      mem_q[wr_ptr_q] <= rec_in;
    end
  end

endmodule

// File: tb/tb_retire_trace_fifo.sv
// Self-checking bench for retire_trace_fifo against a queue-based
// reference model driven by randomized retirement traffic.
`timescale 1ns/1ps
module tb_retire_trace_fifo;

  localparam int DEPTH = 16;
  localparam logic [31:0] SYS = 32'h0000000C;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
  } rec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        retire_valid = 1'b0;
  logic [31:0] retire_pc = '0;
  logic [31:0] retire_instr = '0;
  logic        retire_we = 1'b0;
  logic [4:0]  retire_waddr = '0;
  logic [31:0] retire_wdata = '0;
  logic        out_ready = 1'b0;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic        out_we;
  logic [4:0]  out_waddr;
  logic [31:0] out_wdata;
  logic [4:0]  count;
  logic [31:0] retired_cnt;
  logic        overflow;
  logic        done;

  always #5 clk = ~clk;

  retire_trace_fifo #(.DEPTH(DEPTH)) dut (
    .clk(clk),
    .reset(reset),
    .retire_valid(retire_valid),
    .retire_pc(retire_pc),
    .retire_instr(retire_instr),
    .retire_we(retire_we),
    .retire_waddr(retire_waddr),
    .retire_wdata(retire_wdata),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_pc(out_pc),
    .out_instr(out_instr),
    .out_we(out_we),
    .out_waddr(out_waddr),
    .out_wdata(out_wdata),
    .count(count),
    .retired_cnt(retired_cnt),
    .overflow(overflow),
    .done(done)
  );

  // Reference model: a queue of records plus the sticky flags.
  rec_t        mq[$];
  int unsigned m_ret = 0;
  bit          m_ovf = 1'b0;
  bit          m_done = 1'b0;
  int          m_mode = 0;
  int          checks = 0;
  int          failures = 0;

  function automatic rec_t dhead();
    return {out_pc, out_instr, out_we, out_waddr, out_wdata};
  endfunction

  function automatic logic [39:0] dstat();
    return {count, retired_cnt, overflow, done, out_valid};
  endfunction

  function automatic logic [39:0] mstat();
    logic [4:0] c;
    logic       v;
    c = 5'(mq.size());
    v = (mq.size() != 0) && (m_mode != 2);
    return {c, 32'(m_ret), m_ovf, m_done, v};
  endfunction

  function automatic rec_t mkrec(input int i);
    rec_t r;
    r.pc    = 32'h0040_0000 + 32'(i * 4);
    r.instr = $urandom;
    if (r.instr == SYS) r.instr = 32'h0000_0013;
    r.we    = 1'($urandom_range(0, 1));
    r.waddr = 5'($urandom_range(0, 31));
    r.wdata = $urandom;
    return r;
  endfunction

  task automatic drive(input bit v, input rec_t r);
    retire_valid = v;
    {retire_pc, retire_instr, retire_we, retire_waddr, retire_wdata} = r;
  endtask

  task automatic cyc();
    bit   vld, pp, ph;
    rec_t r, h;
    vld = (mq.size() != 0) && (m_mode != 2);
    pp  = vld && out_ready;
    ph  = retire_valid && (m_mode == 0) && ((mq.size() < DEPTH) || pp);
    r   = {retire_pc, retire_instr, retire_we, retire_waddr, retire_wdata};
    @(posedge clk);
    #1;
    if (!reset) begin
      mq.delete();
      m_ret  = 0;
      m_ovf  = 1'b0;
      m_done = 1'b0;
      m_mode = 0;
    end else begin
      if (retire_valid && (m_mode == 0) && !ph) m_ovf = 1'b1;
      if (pp) begin
        h = mq.pop_front();
        if ((m_mode == 1) && (h.instr == SYS)) begin
          m_mode = 2;
          m_done = 1'b1;
        end
      end
      if (ph) begin
        mq.push_back(r);
        m_ret++;
        if (r.instr == SYS) m_mode = 1;
      end
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    drive(1'b0, '0);
    out_ready = 1'b0;
    cyc();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (dstat() !== 40'h0) begin
      failures++;
      $display("FAIL reset_state got=%h exp=%h", dstat(), 40'h0);
    end
    checks++;
    if (dstat() !== mstat()) begin
      failures++;
      $display("FAIL reset_model got=%h exp=%h", dstat(), mstat());
    end
  endtask

  task automatic test_single();
    rec_t r;
    r = '{pc: 32'h0040_0000, instr: 32'h2002_0005, we: 1'b1,
          waddr: 5'd2, wdata: 32'd5};
    out_ready = 1'b0;
    drive(1'b1, r);
    cyc();
    drive(1'b0, '0);
    checks++;
    if (out_valid !== 1'b1 || dhead() !== r) begin
      failures++;
      $display("FAIL single_head got=%b/%h exp=1/%h", out_valid, dhead(), r);
    end
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
    checks++;
    if ({count, retired_cnt, out_valid} !== {5'd0, 32'd1, 1'b0}) begin
      failures++;
      $display("FAIL single_pop got=%0d/%0d/%b exp=0/1/0",
               count, retired_cnt, out_valid);
    end
  endtask

  task automatic test_fill_overflow();
    rec_t sent[17];
    int   n;
    do_reset();
    for (int i = 0; i < 17; i++) begin
      sent[i] = mkrec(100 + i);
      drive(1'b1, sent[i]);
      cyc();
    end
    drive(1'b0, '0);
    checks++;
    if ({count, overflow, retired_cnt} !== {5'd16, 1'b1, 32'd16}) begin
      failures++;
      $display("FAIL fill_state got=%0d/%b/%0d exp=16/1/16",
               count, overflow, retired_cnt);
    end
    checks++;
    if (dstat() !== mstat()) begin
      failures++;
      $display("FAIL fill_model got=%h exp=%h", dstat(), mstat());
    end
    out_ready = 1'b1;
    n = 0;
    for (int k = 0; k < 40 && out_valid; k++) begin
      checks++;
      if (n >= 16 || dhead() !== sent[n]) begin
        failures++;
        $display("FAIL fill_drain idx=%0d got=%h", n, dhead());
      end
      n++;
      cyc();
    end
    out_ready = 1'b0;
    checks++;
    if (n != 16) begin
      failures++;
      $display("FAIL fill_drain_count got=%0d exp=16", n);
    end
  endtask

  task automatic test_full_push_pop();
    rec_t r17;
    rec_t last;
    int   n;
    do_reset();
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, mkrec(200 + i));
      cyc();
    end
    r17 = mkrec(216);
    drive(1'b1, r17);
    out_ready = 1'b1;
    cyc();
    drive(1'b0, '0);
    out_ready = 1'b0;
    checks++;
    if ({count, overflow, retired_cnt} !== {5'd16, 1'b0, 32'd17}) begin
      failures++;
      $display("FAIL fullpp_state got=%0d/%b/%0d exp=16/0/17",
               count, overflow, retired_cnt);
    end
    out_ready = 1'b1;
    n = 0;
    last = '0;
    for (int k = 0; k < 40 && out_valid; k++) begin
      checks++;
      if (mq.size() == 0 || dhead() !== mq[0]) begin
        failures++;
        $display("FAIL fullpp_drain idx=%0d got=%h", n, dhead());
      end
      last = dhead();
      n++;
      cyc();
    end
    out_ready = 1'b0;
    checks++;
    if (n != 16 || last !== r17) begin
      failures++;
      $display("FAIL fullpp_last got=%0d/%h exp=16/%h", n, last, r17);
    end
  endtask

  task automatic test_backpressure();
    int   pushed;
    int   drained;
    bit   held;
    rec_t hv;
    do_reset();
    pushed = 0;
    drained = 0;
    for (int c = 0; c < 3000 && drained < 100; c++) begin
      out_ready = 1'($urandom_range(0, 1));
      if (pushed < 100 && mq.size() < DEPTH && $urandom_range(0, 3) != 0) begin
        drive(1'b1, mkrec(1000 + pushed));
        pushed++;
      end else begin
        drive(1'b0, '0);
      end
      checks++;
      if (out_valid !== (mq.size() != 0)) begin
        failures++;
        $display("FAIL bp_valid got=%b exp=%b", out_valid, mq.size() != 0);
      end
      if (out_valid && out_ready) begin
        checks++;
        if (mq.size() == 0 || dhead() !== mq[0] ||
            out_pc !== 32'h0040_0000 + 32'((1000 + drained) * 4)) begin
          failures++;
          $display("FAIL bp_order idx=%0d got=%h", drained, out_pc);
        end
        drained++;
      end
      held = out_valid && !out_ready;
      hv = dhead();
      cyc();
      if (held) begin
        checks++;
        if (out_valid !== 1'b1 || dhead() !== hv) begin
          failures++;
          $display("FAIL bp_hold got=%b/%h exp=1/%h", out_valid, dhead(), hv);
        end
      end
    end
    drive(1'b0, '0);
    out_ready = 1'b0;
    checks++;
    if (drained != 100 || retired_cnt !== 32'd100) begin
      failures++;
      $display("FAIL bp_total got=%0d/%0d exp=100/100", drained, retired_cnt);
    end
  endtask

  task automatic test_end_of_test();
    rec_t seq[4];
    do_reset();
    for (int i = 0; i < 4; i++) seq[i] = mkrec(2000 + i);
    seq[2].instr = SYS;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, seq[i]);
      cyc();
    end
    checks++;
    if ({count, retired_cnt, overflow} !== {5'd3, 32'd3, 1'b0}) begin
      failures++;
      $display("FAIL eot_fill got=%0d/%0d/%b exp=3/3/0",
               count, retired_cnt, overflow);
    end
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (out_valid !== 1'b1 || done !== 1'b0 || dhead() !== seq[k]) begin
        failures++;
        $display("FAIL eot_drain idx=%0d got=%b/%b/%h exp=1/0/%h",
                 k, out_valid, done, dhead(), seq[k]);
      end
      cyc();
    end
    checks++;
    if ({done, out_valid, count, retired_cnt} !== {1'b1, 1'b0, 5'd0, 32'd3}) begin
      failures++;
      $display("FAIL eot_done got=%b/%b/%0d/%0d exp=1/0/0/3",
               done, out_valid, count, retired_cnt);
    end
    for (int k = 0; k < 3; k++) cyc();
    checks++;
    if (dstat() !== mstat() || done !== 1'b1 || retired_cnt !== 32'd3) begin
      failures++;
      $display("FAIL eot_halted got=%h exp=%h", dstat(), mstat());
    end
    drive(1'b0, '0);
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    rec_t r;
    do_reset();
    for (int i = 0; i < 17; i++) begin
      drive(1'b1, mkrec(3000 + i));
      cyc();
    end
    drive(1'b0, '0);
    out_ready = 1'b1;
    for (int i = 0; i < 11; i++) cyc();
    out_ready = 1'b0;
    checks++;
    if ({count, overflow} !== {5'd5, 1'b1}) begin
      failures++;
      $display("FAIL rmid_pre got=%0d/%b exp=5/1", count, overflow);
    end
    reset = 1'b0;
    cyc();
    reset = 1'b1;
    checks++;
    if (dstat() !== 40'h0) begin
      failures++;
      $display("FAIL rmid_reset got=%h exp=%h", dstat(), 40'h0);
    end
    r = mkrec(4000);
    drive(1'b1, r);
    cyc();
    drive(1'b0, '0);
    checks++;
    if (out_valid !== 1'b1 || dhead() !== r ||
        {count, retired_cnt} !== {5'd1, 32'd1}) begin
      failures++;
      $display("FAIL rmid_push got=%b/%h/%0d exp=1/%h/1",
               out_valid, dhead(), count, r);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill_overflow();
    test_full_push_pop();
    test_backpressure();
    test_end_of_test();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
